// File: rtl/data_ram_pkg.sv
// Shared sizing constants and helpers for the data RAM arbiter slice.
package data_ram_pkg;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 32;
  localparam int BYTE_EN_W  = DEF_DATA_W / 8;
  localparam logic [BYTE_EN_W-1:0] WEN_READ = '0;

  function automatic logic [1:0] port_onehot(input logic port);
    return port ? 2'b10 : 2'b01;
  endfunction
endpackage

// File: rtl/data_ram_arbiter_if.sv
// Request/response bus for both client ports plus the RAM-facing access signals.
interface data_ram_arbiter_if
  import data_ram_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  localparam int BE_W = DATA_W / 8;

  logic [1:0]                req_valid;
  logic [1:0]                req_ready;
  logic [1:0][BE_W-1:0]      req_wen;
  logic [1:0][ADDR_W-1:0]    req_addr;
  logic [1:0][DATA_W-1:0]    req_wdata;
  logic [1:0]                resp_valid;
  logic [1:0]                resp_ready;
  logic [DATA_W-1:0]         resp_rdata;
  logic [BE_W-1:0]           ram_wen;
  logic [ADDR_W-1:0]         ram_addr;
  logic [DATA_W-1:0]         ram_wdata;
  logic [DATA_W-1:0]         ram_rdata;

  modport slave (
    input  req_valid, req_wen, req_addr, req_wdata, resp_ready, ram_rdata,
    output req_ready, resp_valid, resp_rdata, ram_wen, ram_addr, ram_wdata
  );

  modport master (
    output req_valid, req_wen, req_addr, req_wdata, resp_ready, ram_rdata,
    input  req_ready, resp_valid, resp_rdata, ram_wen, ram_addr, ram_wdata
  );
endinterface

// File: rtl/data_ram_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter; the port that last won loses a tie.
module data_ram_arbiter_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic [1:0] grant_o,
  output logic       grant_port_o
);
  logic last_grant_q, last_grant_d;

  always_comb begin
    grant_o = req_i;
    if (&req_i) grant_o = last_grant_q ? 2'b01 : 2'b10;
    grant_port_o = grant_o[1];
    last_grant_d = (accept_i && |req_i) ? grant_port_o : last_grant_q;
  end

  // Reset value 1 lets port 0 win the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_grant_q <= 1'b1;
    else     last_grant_q <= last_grant_d;
  end
endmodule

// File: rtl/data_ram_arbiter.sv
// Two-port round-robin front end for the byte-writable data RAM:
// command register -> RAM access -> response register, stalled by response backpressure.
module data_ram_arbiter
  import data_ram_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic          clk,
  input  logic          rst,
  data_ram_arbiter_if.slave bus
);
  localparam int BE_W = DATA_W / 8;

  logic              cmd_vld_q,   cmd_vld_d;
  logic              cmd_port_q,  cmd_port_d;
  logic [BE_W-1:0]   cmd_wen_q,   cmd_wen_d;
  logic [ADDR_W-1:0] cmd_addr_q,  cmd_addr_d;
  logic [DATA_W-1:0] cmd_wdata_q, cmd_wdata_d;
  logic [1:0]        resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;

  logic       advance, accept, resp_port, grant_port;
  logic [1:0] grant, req_ready;

  assign resp_port = resp_valid_q[1];
  assign advance   = ~|resp_valid_q | bus.resp_ready[resp_port];
  assign accept    = ~cmd_vld_q | advance;

  data_ram_arbiter_rr_arb2 u_arb (
    .clk          (clk),
    .rst          (rst),
    .req_i        (bus.req_valid),
    .accept_i     (accept),
    .grant_o      (grant),
    .grant_port_o (grant_port)
  );

  assign req_ready = grant & {2{accept}};

  always_comb begin
    cmd_vld_d    = cmd_vld_q;
    cmd_port_d   = cmd_port_q;
    cmd_wen_d    = cmd_wen_q;
    cmd_addr_d   = cmd_addr_q;
    cmd_wdata_d  = cmd_wdata_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    if (|req_ready) begin
      cmd_vld_d   = 1'b1;
      cmd_port_d  = grant_port;
      cmd_wen_d   = bus.req_wen[grant_port];
      cmd_addr_d  = bus.req_addr[grant_port];
      cmd_wdata_d = bus.req_wdata[grant_port];
    end else if (cmd_vld_q && advance) begin
      cmd_vld_d = 1'b0;
    end
    // ram_rdata is sampled on the same edge the write commits, so writes return the old word.
    if (advance) begin
      resp_valid_d = cmd_vld_q ? port_onehot(cmd_port_q) : 2'b00;
      if (cmd_vld_q) resp_rdata_d = bus.ram_rdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_vld_q    <= 1'b0;
      cmd_port_q   <= 1'b0;
      cmd_wen_q    <= '0;
      cmd_addr_q   <= '0;
      cmd_wdata_q  <= '0;
      resp_valid_q <= 2'b00;
      resp_rdata_q <= '0;
    end else begin
      cmd_vld_q    <= cmd_vld_d;
      cmd_port_q   <= cmd_port_d;
      cmd_wen_q    <= cmd_wen_d;
      cmd_addr_q   <= cmd_addr_d;
      cmd_wdata_q  <= cmd_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  // Requests held during reset must not look accepted.
  assign bus.req_ready  = req_ready & ~{2{rst}};
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.ram_wen    = (cmd_vld_q && advance) ? cmd_wen_q : BE_W'(WEN_READ);
  assign bus.ram_addr   = cmd_addr_q;
  assign bus.ram_wdata  = cmd_wdata_q;
endmodule
